// File: rtl/order_msg_encoder.sv
// order_msg_encoder
// Serialises one add / cancel / execute order command into a framed byte stream and hands it to
// uart_tx one byte at a time. Every frame ends in a checksum byte equal to the XOR of all
// earlier bytes in that frame.
//
// Ports:
//   i_Clk, i_Resetn    clock; synchronous active-low reset
//   i_Start            command strobe, honoured only while idle
//   i_Request          3'b001 add, 3'b010 cancel, 3'b100 execute (others flag o_Error)
//   i_StockId, i_OrderId, i_OrderType, i_Price, i_Quantity   command fields
//   i_TxBusy           uart_tx busy
//   o_TxStart/o_TxData one-cycle send strobe and the byte being sent
//   o_Busy             frame in progress
//   o_Done             one-cycle pulse when the frame is complete
//   o_Error            one-cycle pulse for an invalid request
module order_msg_encoder #(
  parameter logic [7:0]  ADD_HDR  = 8'h41,
  parameter logic [7:0]  CXL_HDR  = 8'h58,
  parameter logic [7:0]  EXE_HDR  = 8'h45,
  parameter int unsigned ACK_WAIT = 4
) (
  input  logic        i_Clk,
  input  logic        i_Resetn,
  input  logic        i_Start,
  input  logic [2:0]  i_Request,
  input  logic [1:0]  i_StockId,
  input  logic [7:0]  i_OrderId,
  input  logic        i_OrderType,
  input  logic [31:0] i_Price,
  input  logic [7:0]  i_Quantity,
  input  logic        i_TxBusy,
  output logic        o_TxStart,
  output logic [7:0]  o_TxData,
  output logic        o_Busy,
  output logic        o_Done,
  output logic        o_Error
);

  localparam int unsigned AckCntW = (ACK_WAIT > 1) ? $clog2(ACK_WAIT) : 1;
  localparam logic [AckCntW-1:0] AckLast = AckCntW'(ACK_WAIT - 1);

  typedef enum logic [2:0] {
    StIdle,
    StSend,
    StWaitAck,
    StWaitDone,
    StFinish
  } state_e;

  state_e             state_q;
  logic               add_q;
  logic               cxl_q;
  logic [7:0]         order_q;
  logic [1:0]         stock_q;
  logic               type_q;
  logic [31:0]        price_q;
  logic [7:0]         qty_q;
  logic [3:0]         len_q;
  logic [3:0]         idx_q;
  logic [7:0]         chk_q;
  logic [AckCntW-1:0] ack_cnt_q;
  logic               tx_start_q;
  logic [7:0]         tx_data_q;
  logic               busy_q;
  logic               done_q;
  logic               error_q;

  logic               req_valid;
  logic               is_chk_byte;
  logic [7:0]         byte_d;

  assign req_valid   = (i_Request == 3'b001) || (i_Request == 3'b010) || (i_Request == 3'b100);
  assign is_chk_byte = (idx_q == (len_q - 4'd1));

  // Byte at the current index, built only from latched fields.
  always_comb begin
    byte_d = 8'h00;
    if (is_chk_byte) begin
      byte_d = chk_q;
    end else begin
      case (idx_q)
        4'd0:    byte_d = add_q ? ADD_HDR : (cxl_q ? CXL_HDR : EXE_HDR);
        4'd1:    byte_d = order_q;
        4'd2:    byte_d = {6'b0, stock_q};
        // Index 3 is the order type for add and the quantity for execute.
        4'd3:    byte_d = add_q ? {7'b0, type_q} : qty_q;
        4'd4:    byte_d = price_q[31:24];
        4'd5:    byte_d = price_q[23:16];
        4'd6:    byte_d = price_q[15:8];
        4'd7:    byte_d = price_q[7:0];
        4'd8:    byte_d = qty_q;
        default: byte_d = 8'h00;
      endcase
    end
  end

  always_ff @(posedge i_Clk) begin
    if (!i_Resetn) begin
      state_q    <= StIdle;
      add_q      <= 1'b0;
      cxl_q      <= 1'b0;
      order_q    <= 8'h00;
      stock_q    <= 2'b00;
      type_q     <= 1'b0;
      price_q    <= 32'h0;
      qty_q      <= 8'h00;
      len_q      <= 4'd0;
      idx_q      <= 4'd0;
      chk_q      <= 8'h00;
      ack_cnt_q  <= '0;
      tx_start_q <= 1'b0;
      tx_data_q  <= 8'h00;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      tx_start_q <= 1'b0;
      done_q     <= 1'b0;
      error_q    <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (i_Start) begin
            if (req_valid) begin
              add_q   <= i_Request[0];
              cxl_q   <= i_Request[1];
              order_q <= i_OrderId;
              stock_q <= i_StockId;
              type_q  <= i_OrderType;
              price_q <= i_Price;
              qty_q   <= i_Quantity;
              len_q   <= i_Request[0] ? 4'd10 : (i_Request[1] ? 4'd4 : 4'd5);
              idx_q   <= 4'd0;
              chk_q   <= 8'h00;
              busy_q  <= 1'b1;
              state_q <= StSend;
            end else begin
              error_q <= 1'b1;
            end
          end
        end
        StSend: begin
          if (!i_TxBusy) begin
            tx_start_q <= 1'b1;
            tx_data_q  <= byte_d;
            if (!is_chk_byte) begin
              chk_q <= chk_q ^ byte_d;
            end
            ack_cnt_q <= '0;
            state_q   <= StWaitAck;
          end
        end
        StWaitAck: begin
          // A uart that never acknowledges must not stall the frame.
          if (i_TxBusy || (ack_cnt_q == AckLast)) begin
            state_q <= StWaitDone;
          end else begin
            ack_cnt_q <= ack_cnt_q + 1'b1;
          end
        end
        StWaitDone: begin
          if (!i_TxBusy) begin
            idx_q   <= idx_q + 4'd1;
            state_q <= ((idx_q + 4'd1) == len_q) ? StFinish : StSend;
          end
        end
        StFinish: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          idx_q   <= 4'd0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_TxStart = tx_start_q;
  assign o_TxData  = tx_data_q;
  assign o_Busy    = busy_q;
  assign o_Done    = done_q;
  assign o_Error   = error_q;

endmodule

// File: tb/tb_order_msg_encoder.sv
module tb_order_msg_encoder;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_Start = 1'b0;
  logic [2:0]  i_Request = 3'b000;
  logic [1:0]  i_StockId = 2'd0;
  logic [7:0]  i_OrderId = 8'h00;
  logic        i_OrderType = 1'b0;
  logic [31:0] i_Price = 32'h0;
  logic [7:0]  i_Quantity = 8'h00;
  logic        i_TxBusy = 1'b0;
  logic        o_TxStart;
  logic [7:0]  o_TxData;
  logic        o_Busy;
  logic        o_Done;
  logic        o_Error;

  order_msg_encoder dut (
    .i_Clk      (clk),
    .i_Resetn   (rstn),
    .i_Start    (i_Start),
    .i_Request  (i_Request),
    .i_StockId  (i_StockId),
    .i_OrderId  (i_OrderId),
    .i_OrderType(i_OrderType),
    .i_Price    (i_Price),
    .i_Quantity (i_Quantity),
    .i_TxBusy   (i_TxBusy),
    .o_TxStart  (o_TxStart),
    .o_TxData   (o_TxData),
    .o_Busy     (o_Busy),
    .o_Done     (o_Done),
    .o_Error    (o_Error)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int mode = 0;  // 0: busy 10 cycles, 1: never busy, 2: random busy length
  int busy_cnt = 0;
  logic [7:0] bytes[$];
  int start_cyc[$];
  int done_n = 0;
  int err_n = 0;
  int busy_done_bad = 0;
  int viol = 0;
  logic [7:0] exp_b[10];

  always @(posedge clk) cyc <= cyc + 1;

  // uart_tx model
  always @(posedge clk) begin
    if (busy_cnt > 0) begin
      busy_cnt <= busy_cnt - 1;
      if (busy_cnt == 1) i_TxBusy <= 1'b0;
    end else if (o_TxStart && mode != 1) begin
      i_TxBusy <= 1'b1;
      busy_cnt <= (mode == 2) ? int'($urandom_range(1, 12)) : 10;
    end
  end

  always @(negedge clk) begin
    if (o_TxStart) begin
      bytes.push_back(o_TxData);
      start_cyc.push_back(cyc);
      if (i_TxBusy) viol++;
    end
    if (o_Done) begin
      done_n++;
      if (o_Busy) busy_done_bad++;
    end
    if (o_Error) err_n++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clear_logs();
    @(posedge clk);
    #1;
    bytes.delete();
    start_cyc.delete();
    done_n = 0;
    err_n = 0;
    busy_done_bad = 0;
  endtask

  task automatic issue(input logic [2:0] r, input logic [7:0] o, input logic [1:0] s,
                       input logic t, input logic [31:0] p, input logic [7:0] q);
    @(negedge clk);
    i_Request = r;
    i_OrderId = o;
    i_StockId = s;
    i_OrderType = t;
    i_Price = p;
    i_Quantity = q;
    i_Start = 1'b1;
    @(negedge clk);
    i_Start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n = 0;
    while (done_n == 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_done_seen"}, 32'(done_n != 0), 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_frame(input string tag, input int n);
    chk({tag, "_nbytes"}, 32'(bytes.size()), 32'(n));
    for (int i = 0; i < n; i++) begin
      if (i < bytes.size()) chk($sformatf("%s_b%0d", tag, i), 32'(bytes[i]), 32'(exp_b[i]));
    end
    chk({tag, "_ndone"}, 32'(done_n), 32'd1);
    chk({tag, "_nerr"}, 32'(err_n), 32'd0);
    chk({tag, "_busy_at_done"}, 32'(busy_done_bad), 32'd0);
    chk({tag, "_busy_after"}, 32'(o_Busy), 32'd0);
  endtask

  initial begin
    // Reset state
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", 32'({o_TxStart, o_TxData, o_Busy, o_Done, o_Error}), 32'd0);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    // Add frame, with a second start and field changes mid-frame
    mode = 0;
    clear_logs();
    issue(3'b001, 8'h05, 2'd2, 1'b1, 32'h0000_0064, 8'h0A);
    chk("add_busy_next_cycle", 32'(o_Busy), 32'd1);
    @(negedge clk);
    chk("add_first_start_latency", 32'(o_TxStart), 32'd1);
    repeat (30) @(negedge clk);
    issue(3'b010, 8'hFF, 2'd3, 1'b0, 32'hDEAD_BEEF, 8'h77);
    i_Request = 3'b011;
    i_Quantity = 8'h11;
    wait_done("add", 600);
    exp_b = '{8'h41, 8'h05, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h64, 8'h0A, 8'h29};
    check_frame("add", 10);

    // Cancel
    clear_logs();
    issue(3'b010, 8'h07, 2'd1, 1'b0, 32'h0, 8'h00);
    wait_done("cxl", 300);
    exp_b = '{8'h58, 8'h07, 8'h01, 8'h5E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_frame("cxl", 4);

    // Execute
    clear_logs();
    issue(3'b100, 8'h07, 2'd1, 1'b0, 32'h0, 8'h03);
    wait_done("exe", 300);
    exp_b = '{8'h45, 8'h07, 8'h01, 8'h03, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_frame("exe", 5);

    // Invalid request
    clear_logs();
    issue(3'b011, 8'h01, 2'd0, 1'b0, 32'h0, 8'h01);
    chk("inv_error_pulse", 32'(o_Error), 32'd1);
    chk("inv_busy_low", 32'(o_Busy), 32'd0);
    @(negedge clk);
    chk("inv_error_one_cycle", 32'(o_Error), 32'd0);
    repeat (20) @(negedge clk);
    chk("inv_no_bytes", 32'(bytes.size()), 32'd0);
    chk("inv_err_count", 32'(err_n), 32'd1);
    chk("inv_busy_stays_low", 32'(o_Busy), 32'd0);

    // Reset during byte 4 of an add, then a clean cancel
    clear_logs();
    issue(3'b001, 8'h05, 2'd2, 1'b1, 32'h0000_0064, 8'h0A);
    begin
      int n = 0;
      while (bytes.size() < 4 && n < 300) begin
        @(negedge clk);
        n++;
      end
    end
    chk("rst_reached_byte4", 32'(bytes.size()), 32'd4);
    rstn = 1'b0;
    @(negedge clk);
    chk("rst_outputs_zero", 32'({o_TxStart, o_TxData, o_Busy, o_Done, o_Error}), 32'd0);
    @(negedge clk);
    rstn = 1'b1;
    repeat (40) @(negedge clk);
    chk("rst_no_more_bytes", 32'(bytes.size()), 32'd4);
    chk("rst_no_done", 32'(done_n), 32'd0);
    clear_logs();
    issue(3'b010, 8'h07, 2'd1, 1'b0, 32'h0, 8'h00);
    wait_done("rst_cxl", 300);
    exp_b = '{8'h58, 8'h07, 8'h01, 8'h5E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_frame("rst_cxl", 4);

    // uart that never raises busy: each byte advances after the ack timeout
    mode = 1;
    repeat (20) @(negedge clk);
    clear_logs();
    issue(3'b001, 8'h05, 2'd2, 1'b1, 32'h0000_0064, 8'h0A);
    wait_done("nobusy", 300);
    exp_b = '{8'h41, 8'h05, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h64, 8'h0A, 8'h29};
    check_frame("nobusy", 10);
    if (start_cyc.size() >= 2) chk("nobusy_byte_gap", 32'(start_cyc[1] - start_cyc[0]), 32'd6);

    // Random busy lengths
    mode = 2;
    clear_logs();
    issue(3'b100, 8'h07, 2'd1, 1'b0, 32'h0, 8'h03);
    wait_done("rnd_exe", 400);
    exp_b = '{8'h45, 8'h07, 8'h01, 8'h03, 8'h40, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_frame("rnd_exe", 5);
    clear_logs();
    issue(3'b001, 8'h05, 2'd2, 1'b1, 32'h0000_0064, 8'h0A);
    wait_done("rnd_add", 600);
    exp_b = '{8'h41, 8'h05, 8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h64, 8'h0A, 8'h29};
    check_frame("rnd_add", 10);
    clear_logs();
    issue(3'b010, 8'h07, 2'd1, 1'b0, 32'h0, 8'h00);
    wait_done("rnd_cxl", 300);
    exp_b = '{8'h58, 8'h07, 8'h01, 8'h5E, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
    check_frame("rnd_cxl", 4);

    chk("start_while_busy", 32'(viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
